// File: rtl/hazard_ctrl.sv
// Front-end sequencing controller: decides load/hold/flush/bubble for PC, IF/ID
// and ID/EX each cycle, and counts cycles in which the PC did not advance.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             flushing,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [1:0]       FCNT_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_reg, state_next;
   logic [1:0]       fcnt_reg, fcnt_next;
   logic [CNT_W-1:0] stall_count_reg;
   logic             hz;

   assign hz = id_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      state_next   = state_reg;
      fcnt_next    = fcnt_reg;
      if (rst) begin
         pc_en        = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_next   = RUN;
         fcnt_next    = 2'd0;
      end else if (mem_busy) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         id_ex_en = 1'b0;
      end else if (br_taken) begin
         // A branch seen during FLUSH restarts the count from the top.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            fcnt_next  = FCNT_INIT;
         end else begin
            state_next = RUN;
            fcnt_next  = 2'd0;
         end
      end else if (state_reg == FLUSH) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         fcnt_next    = fcnt_reg - 2'd1;
         if (fcnt_reg == 2'd1) begin
            state_next = RUN;
         end
      end else if (hz) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= RUN;
         fcnt_reg        <= 2'd0;
         stall_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         fcnt_reg  <= fcnt_next;
         if (!pc_en && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
         end
      end
   end

   assign flushing    = (state_reg == FLUSH);
   assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (3-cycle flush / 4-bit counter and
// 1-cycle flush / 16-bit counter) driven by the same inputs, checked against a model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_uses_rs = 1'b0;
   logic       id_uses_rt = 1'b0;
   logic       ex_mem_read = 1'b0;
   logic [4:0] ex_rd = '0;
   logic       br_taken = 1'b0;
   logic       mem_busy = 1'b0;

   logic        pc_en_o [2];
   logic        if_id_en_o [2];
   logic        if_id_flush_o [2];
   logic        id_ex_en_o [2];
   logic        id_ex_bubble_o [2];
   logic        flushing_o [2];
   logic [15:0] sc_o [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int FC = (gi == 0) ? 3 : 1;
      localparam int CW = (gi == 0) ? 4 : 16;
      logic [CW-1:0] sc;
      hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut (
         .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
         .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
         .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
         .pc_en(pc_en_o[gi]), .if_id_en(if_id_en_o[gi]), .if_id_flush(if_id_flush_o[gi]),
         .id_ex_en(id_ex_en_o[gi]), .id_ex_bubble(id_ex_bubble_o[gi]),
         .flushing(flushing_o[gi]), .stall_count(sc));
      assign sc_o[gi] = 16'(sc);
   end

   typedef struct {
      bit       rst, valid;
      bit [4:0] rs, rt;
      bit       urs, urt, mr;
      bit [4:0] rd;
      bit       br, mb;
      bit       pc, ifen, iffl, exen, bub, fl;
      int       cnt;
   } vec_t;

   // Model state: flush cycles still owed after the current one, stall count.
   int  m_rem [2];
   int  m_cnt [2];
   bit  m_known = 1'b0;
   int  m_fc  [2] = '{3, 1};
   int  m_max [2] = '{15, 65535};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int r, input int v, input int rs, input int rt,
                               input int urs, input int urt, input int mr, input int rd,
                               input int br, input int mb, input int pc, input int ifen,
                               input int iffl, input int exen, input int bub, input int fl,
                               input int cnt);
      vec_t t;
      t.rst = r[0]; t.valid = v[0]; t.rs = rs[4:0]; t.rt = rt[4:0];
      t.urs = urs[0]; t.urt = urt[0]; t.mr = mr[0]; t.rd = rd[4:0];
      t.br = br[0]; t.mb = mb[0];
      t.pc = pc[0]; t.ifen = ifen[0]; t.iffl = iffl[0]; t.exen = exen[0];
      t.bub = bub[0]; t.fl = fl[0]; t.cnt = cnt;
      return t;
   endfunction

   function automatic vec_t rnd_vec(input bit r, input bit force_mb);
      vec_t t;
      t = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0);
      t.rst   = r;
      t.valid = ($urandom_range(0, 3) != 0);
      t.rs    = 5'($urandom_range(0, 3));
      t.rt    = 5'($urandom_range(0, 3));
      t.urs   = 1'($urandom_range(0, 1));
      t.urt   = 1'($urandom_range(0, 1));
      t.mr    = 1'($urandom_range(0, 1));
      t.rd    = 5'($urandom_range(0, 3));
      t.br    = ($urandom_range(0, 5) == 0);
      t.mb    = force_mb | ($urandom_range(0, 3) == 0);
      return t;
   endfunction

   task automatic step(input string tag, input vec_t v, input bit use_exp);
      int e_pc, e_ifen, e_iffl, e_exen, e_bub, e_fl, n_rem, n_cnt;
      bit hz;
      rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
      id_uses_rs = v.urs; id_uses_rt = v.urt; ex_mem_read = v.mr; ex_rd = v.rd;
      br_taken = v.br; mem_busy = v.mb;
      @(negedge clk);
      hz = v.valid && v.mr && (v.rd != 0) &&
           ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
      for (int k = 0; k < 2; k++) begin
         n_rem = m_rem[k];
         n_cnt = m_cnt[k];
         e_fl  = (m_rem[k] > 0) ? 1 : 0;
         if (v.rst) begin
            {e_pc, e_ifen, e_iffl, e_exen, e_bub} = {32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
            n_rem = 0;
            n_cnt = 0;
         end else if (v.mb) begin
            {e_pc, e_ifen, e_iffl, e_exen, e_bub} = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
         end else if (v.br || m_rem[k] > 0) begin
            {e_pc, e_ifen, e_iffl, e_exen, e_bub} = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
            n_rem = v.br ? m_fc[k] - 1 : m_rem[k] - 1;
         end else if (hz) begin
            {e_pc, e_ifen, e_iffl, e_exen, e_bub} = {32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
         end else begin
            {e_pc, e_ifen, e_iffl, e_exen, e_bub} = {32'd1, 32'd1, 32'd0, 32'd1, 32'd0};
         end
         if (!v.rst && e_pc == 0 && m_cnt[k] < m_max[k]) n_cnt = m_cnt[k] + 1;
         chk($sformatf("%s d%0d pc_en", tag, k), int'(pc_en_o[k]), e_pc);
         chk($sformatf("%s d%0d if_id_en", tag, k), int'(if_id_en_o[k]), e_ifen);
         chk($sformatf("%s d%0d if_id_flush", tag, k), int'(if_id_flush_o[k]), e_iffl);
         chk($sformatf("%s d%0d id_ex_en", tag, k), int'(id_ex_en_o[k]), e_exen);
         chk($sformatf("%s d%0d id_ex_bubble", tag, k), int'(id_ex_bubble_o[k]), e_bub);
         if (m_known) begin
            chk($sformatf("%s d%0d flushing", tag, k), int'(flushing_o[k]), e_fl);
            chk($sformatf("%s d%0d stall_count", tag, k), int'(sc_o[k]), m_cnt[k]);
         end
         m_rem[k] = n_rem;
         m_cnt[k] = n_cnt;
      end
      if (use_exp) begin
         chk({tag, " tbl pc_en"}, int'(pc_en_o[0]), int'(v.pc));
         chk({tag, " tbl if_id_en"}, int'(if_id_en_o[0]), int'(v.ifen));
         chk({tag, " tbl if_id_flush"}, int'(if_id_flush_o[0]), int'(v.iffl));
         chk({tag, " tbl id_ex_en"}, int'(id_ex_en_o[0]), int'(v.exen));
         chk({tag, " tbl id_ex_bubble"}, int'(id_ex_bubble_o[0]), int'(v.bub));
         chk({tag, " tbl flushing"}, int'(flushing_o[0]), int'(v.fl));
         chk({tag, " tbl stall_count"}, int'(sc_o[0]), v.cnt);
      end
      $display("%s rst=%0d mb=%0d br=%0d hz=%0d | pc=%0d ifen=%0d iffl=%0d exen=%0d bub=%0d fl=%0d cnt=%0d",
               tag, v.rst, v.mb, v.br, hz, pc_en_o[0], if_id_en_o[0], if_id_flush_o[0],
               id_ex_en_o[0], id_ex_bubble_o[0], flushing_o[0], sc_o[0]);
      if (v.rst) m_known = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[$];
      // rst v rs rt urs urt mr rd br mb | pc ifen iffl exen bub fl | cnt (3-cycle instance)
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0, 0));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,0,0, 0,0,0,1,1,0, 0));
      tbl.push_back(mk(0,1,5,0,1,0,0,3,0,0, 1,1,0,1,0,0, 1));
      tbl.push_back(mk(0,1,0,0,1,0,1,0,0,0, 1,1,0,1,0,0, 1));
      tbl.push_back(mk(0,1,5,0,0,0,1,5,0,0, 1,1,0,1,0,0, 1));
      tbl.push_back(mk(0,1,0,7,0,1,1,7,0,0, 0,0,0,1,1,0, 1));
      tbl.push_back(mk(0,0,0,7,0,1,1,7,0,0, 1,1,0,1,0,0, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,1,1,1,0, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,0,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,1,1,1,0, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0, 2));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,1,1, 0,0,0,0,0,0, 2));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,1,1, 0,0,0,0,0,0, 3));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,1,1, 0,0,0,0,0,0, 4));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,1,1, 0,0,0,0,0,0, 5));
      tbl.push_back(mk(0,1,5,0,1,0,1,5,1,0, 1,1,1,1,1,0, 6));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 6));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 6));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0, 6));

      m_rem = '{0, 0};
      m_cnt = '{0, 0};

      for (int i = 0; i < 2; i++) step($sformatf("reset%0d", i), rnd_vec(1'b1, 1'b0), 1'b0);
      chk("post-reset flushing", int'(flushing_o[0]), 0);
      chk("post-reset stall_count", int'(sc_o[0]), 0);

      for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i], 1'b1);

      for (int i = 0; i < 20; i++) begin
         vec_t t;
         t = rnd_vec(1'b0, 1'b1);
         step($sformatf("sat%0d", i), t, 1'b0);
      end
      chk("saturated stall_count", int'(sc_o[0]), 15);

      for (int i = 0; i < 2; i++) step($sformatf("rst%0d", i), rnd_vec(1'b1, 1'b0), 1'b0);
      step("mid_br", mk(0,0,0,0,0,0,0,0,1,0, 1,1,1,1,1,0, 0), 1'b1);
      step("mid_rst", mk(1,0,0,0,0,0,0,0,0,0, 0,1,1,1,1,1, 0), 1'b1);
      chk("mid-flush reset flushing", int'(flushing_o[0]), 0);
      chk("mid-flush reset stall_count", int'(sc_o[0]), 0);
      step("mid_idle", mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0, 0), 1'b1);

      for (int i = 0; i < 600; i++) begin
         vec_t t;
         t = rnd_vec(($urandom_range(0, 63) == 0), 1'b0);
         step($sformatf("rnd%0d", i), t, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
